// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the five-stage MIPS core. A small FSM
//   (RUN / MEMWAIT / LDSTALL / HALTED) sequences data-cache miss waits,
//   load-use stalls, control-flow flushes and halt. It drives the per-stage
//   latch enables, flushes and the PC write enable, and selects EX operand
//   forwarding. It also keeps a saturating stall-cycle counter and a sticky
//   memory-timeout flag for debug.
//
//   Build option: HAZARD_FWD_EN
//     defined   : EX forwarding active; only load-use hazards stall.
//     undefined : no forwarding (fwdA/fwdB = 00); any RAW match against
//                 IDEX or EXMEM stalls until it clears; LOAD_LAT unused.
//
//   Ports
//     CLK, RST                          clock, synchronous active-high reset
//     ihit, dhit                        instruction / data cache hit
//     mem_ren, mem_wen                  MEM-stage data request
//     mem_halt                          HALT reached MEM
//     branch_flush, jump_flush          control redirect resolved
//     id_rs, id_rt, id_use_rs/rt        ID-stage sources and their use flags
//     idex/exmem/memwb_wsel, _regwr     destination registers and enables
//     idex_memread                      EX-stage instruction is a load
//     ex_rs, ex_rt                      EX-stage sources
//     *_enable, *_flush, pcWEN          pipeline control
//     fwdA, fwdB                        00 regfile, 01 EXMEM, 10 MEMWB
//     halted, mem_timeout, stall_cycles debug / status
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              mem_halt,
  input  logic              branch_flush,
  input  logic              jump_flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] idex_wsel,
  input  logic [REG_AW-1:0] exmem_wsel,
  input  logic [REG_AW-1:0] memwb_wsel,
  input  logic              idex_regwr,
  input  logic              exmem_regwr,
  input  logic              memwb_regwr,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              IFID_enable,
  output logic              IFID_flush,
  output logic              IDEX_enable,
  output logic              IDEX_flush,
  output logic              EXMEM_enable,
  output logic              EXMEM_flush,
  output logic              MEMWB_enable,
  output logic              pcWEN,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              halted,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [2:0] LD_CNT = 3'(LOAD_LAT - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, LDSTALL, HALTED} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_inc;
  logic              miss, flush, hit_idex, hit_exmem, data_stall, ld_enter;
  logic              act_run, act_flush, act_stall;

  assign miss  = (mem_ren | mem_wen) & ~dhit;
  assign flush = branch_flush | jump_flush;

  // A used ID source matches a live, non-zero destination.
  always_comb begin
    hit_idex  = idex_regwr && (idex_wsel != '0) &&
                ((id_use_rs && (id_rs == idex_wsel)) || (id_use_rt && (id_rt == idex_wsel)));
    hit_exmem = exmem_regwr && (exmem_wsel != '0) &&
                ((id_use_rs && (id_rs == exmem_wsel)) || (id_use_rt && (id_rt == exmem_wsel)));
  end

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] em_wsel,
                                         input logic              em_wr,
                                         input logic [REG_AW-1:0] mw_wsel,
                                         input logic              mw_wr);
    if (src == '0)                   return 2'b00;
    if (em_wr && (em_wsel == src))   return 2'b01;
    if (mw_wr && (mw_wsel == src))   return 2'b10;
    return 2'b00;
  endfunction

  assign data_stall = idex_memread & hit_idex;
  assign ld_enter   = (LOAD_LAT > 1);

  always_comb begin
    fwdA = fwd_sel(ex_rs, exmem_wsel, exmem_regwr, memwb_wsel, memwb_regwr);
    fwdB = fwd_sel(ex_rt, exmem_wsel, exmem_regwr, memwb_wsel, memwb_regwr);
  end
`else
  logic unused_nofwd;

  // Without forwarding every RAW against IDEX/EXMEM stalls in RUN until the
  // producer retires past EXMEM, so LDSTALL is never entered.
  assign data_stall   = hit_idex | hit_exmem;
  assign ld_enter     = 1'b0;
  assign fwdA         = 2'b00;
  assign fwdB         = 2'b00;
  assign unused_nofwd = ^{idex_memread, ex_rs, ex_rt, memwb_wsel, memwb_regwr};
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_run      = 1'b0;
    act_flush    = 1'b0;
    act_stall    = 1'b0;
    IFID_enable  = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_enable  = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_enable = 1'b0;
    EXMEM_flush  = 1'b0;
    MEMWB_enable = 1'b0;
    pcWEN        = 1'b0;
    halted       = 1'b0;
    wcnt_inc     = (wcnt == WCNT_MAX) ? wcnt : wcnt + WCNT_W'(1);

    unique case (state)
      RUN: begin
        if (mem_halt)        state_nxt = HALTED;
        else if (miss)       state_nxt = MEMWAIT;
        else if (flush)      act_flush = 1'b1;
        else if (data_stall) begin
          act_stall = 1'b1;
          if (ld_enter) begin
            state_nxt = LDSTALL;
            cnt_nxt   = LD_CNT;
          end
        end
        else                 act_run = 1'b1;
      end
      LDSTALL: begin
        if (mem_halt)   state_nxt = HALTED;
        else if (flush) begin
          act_flush = 1'b1;
          state_nxt = RUN;
        end
        else begin
          act_stall = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = RUN;
        end
      end
      MEMWAIT: begin
        if (mem_halt)  state_nxt = HALTED;
        else if (dhit) begin
          // Retire the missing access into MEMWB and bubble EXMEM behind it.
          EXMEM_enable = 1'b1;
          MEMWB_enable = 1'b1;
          EXMEM_flush  = 1'b1;
          state_nxt    = RUN;
        end
      end
      HALTED: halted = 1'b1;
    endcase

    if (act_run | act_flush | act_stall) begin
      IDEX_enable  = ihit;
      EXMEM_enable = ihit;
      MEMWB_enable = ihit;
    end
    if (act_run | act_flush) begin
      IFID_enable = ihit;
      pcWEN       = ihit;
    end
    if (act_flush) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end
    if (act_stall) IDEX_flush = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      cnt          <= '0;
      wcnt         <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == MEMWAIT) begin
        wcnt <= wcnt_inc;
        if (wcnt_inc == WCNT_MAX) mem_timeout <= 1'b1;
      end else begin
        wcnt <= '0;
      end
      if (!pcWEN && (state != HALTED) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [7:0] C_NORM  = 8'hAB;
  localparam logic [7:0] C_FLUSH = 8'hFB;
  localparam logic [7:0] C_STALL = 8'h3A;
  localparam logic [7:0] C_DHIT  = 8'h0E;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, ihit, dhit, mem_ren, mem_wen, mem_halt, branch_flush, jump_flush;
  logic [4:0] id_rs, id_rt, idex_wsel, exmem_wsel, memwb_wsel, ex_rs, ex_rt;
  logic       id_use_rs, id_use_rt, idex_regwr, exmem_regwr, memwb_regwr, idex_memread;

  logic        a_ifid_en, a_ifid_fl, a_idex_en, a_idex_fl, a_exmem_en, a_exmem_fl, a_memwb_en, a_pcwen;
  logic [1:0]  a_fwda, a_fwdb;
  logic        a_halted, a_tmo;
  logic [15:0] a_stall;
  logic        b_ifid_en, b_ifid_fl, b_idex_en, b_idex_fl, b_exmem_en, b_exmem_fl, b_memwb_en, b_pcwen;
  logic [1:0]  b_fwda, b_fwdb;
  logic        b_halted, b_tmo;
  logic [2:0]  b_stall;
  logic [7:0]  ctl_a, ctl_b;

  assign ctl_a = {a_ifid_en, a_ifid_fl, a_idex_en, a_idex_fl, a_exmem_en, a_exmem_fl, a_memwb_en, a_pcwen};
  assign ctl_b = {b_ifid_en, b_ifid_fl, b_idex_en, b_idex_fl, b_exmem_en, b_exmem_fl, b_memwb_en, b_pcwen};

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .MEM_TIMEOUT(8), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_halt(mem_halt), .branch_flush(branch_flush), .jump_flush(jump_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .idex_wsel(idex_wsel), .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
    .idex_regwr(idex_regwr), .exmem_regwr(exmem_regwr), .memwb_regwr(memwb_regwr),
    .idex_memread(idex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .IFID_enable(a_ifid_en), .IFID_flush(a_ifid_fl), .IDEX_enable(a_idex_en), .IDEX_flush(a_idex_fl),
    .EXMEM_enable(a_exmem_en), .EXMEM_flush(a_exmem_fl), .MEMWB_enable(a_memwb_en), .pcWEN(a_pcwen),
    .fwdA(a_fwda), .fwdB(a_fwdb), .halted(a_halted), .mem_timeout(a_tmo), .stall_cycles(a_stall)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(4), .MEM_TIMEOUT(255), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_halt(mem_halt), .branch_flush(branch_flush), .jump_flush(jump_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .idex_wsel(idex_wsel), .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
    .idex_regwr(idex_regwr), .exmem_regwr(exmem_regwr), .memwb_regwr(memwb_regwr),
    .idex_memread(idex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .IFID_enable(b_ifid_en), .IFID_flush(b_ifid_fl), .IDEX_enable(b_idex_en), .IDEX_flush(b_idex_fl),
    .EXMEM_enable(b_exmem_en), .EXMEM_flush(b_exmem_fl), .MEMWB_enable(b_memwb_en), .pcWEN(b_pcwen),
    .fwdA(b_fwda), .fwdB(b_fwdb), .halted(b_halted), .mem_timeout(b_tmo), .stall_cycles(b_stall)
  );

  typedef struct {
    string      name;
    logic       ihit, mem_ren, dhit, bfl, jfl;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt;
    logic [4:0] idex_wsel, exmem_wsel, memwb_wsel;
    logic       idex_regwr, exmem_regwr, memwb_regwr, idex_memread;
    logic [4:0] ex_rs, ex_rt;
    logic [7:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t base(input string nm);
    vec_t v;
    v.name = nm; v.ihit = 1'b1; v.mem_ren = 1'b0; v.dhit = 1'b0; v.bfl = 1'b0; v.jfl = 1'b0;
    v.id_rs = '0; v.id_rt = '0; v.use_rs = 1'b0; v.use_rt = 1'b0;
    v.idex_wsel = '0; v.exmem_wsel = '0; v.memwb_wsel = '0;
    v.idex_regwr = 1'b0; v.exmem_regwr = 1'b0; v.memwb_regwr = 1'b0; v.idex_memread = 1'b0;
    v.ex_rs = '0; v.ex_rt = '0; v.ctl = C_NORM; v.fa = 2'b00; v.fb = 2'b00;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ihit = v.ihit; mem_ren = v.mem_ren; dhit = v.dhit; branch_flush = v.bfl; jump_flush = v.jfl;
    id_rs = v.id_rs; id_rt = v.id_rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    idex_wsel = v.idex_wsel; exmem_wsel = v.exmem_wsel; memwb_wsel = v.memwb_wsel;
    idex_regwr = v.idex_regwr; exmem_regwr = v.exmem_regwr; memwb_regwr = v.memwb_regwr;
    idex_memread = v.idex_memread; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    mem_wen = 1'b0; mem_halt = 1'b0;
  endtask

  task automatic idle();
    drive(base("idle"));
  endtask

  task automatic load_use();
    idle();
    idex_memread = 1'b1; idex_regwr = 1'b1; idex_wsel = 5'd2; id_rs = 5'd2; id_use_rs = 1'b1;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle(); ihit = 1'b0; RST = 1'b1;
    cyc();
    RST = 1'b0; ihit = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    v = base("normal");          tbl.push_back(v);
    v = base("no_ihit");         v.ihit = 1'b0; v.ctl = 8'h00; tbl.push_back(v);
    v = base("branch_flush");    v.bfl = 1'b1; v.ctl = C_FLUSH; tbl.push_back(v);
    v = base("jump_flush_noihit"); v.jfl = 1'b1; v.ihit = 1'b0; v.ctl = 8'h50; tbl.push_back(v);
    v = base("fwd_both");        v.ex_rs = 5; v.ex_rt = 5; v.exmem_wsel = 5; v.memwb_wsel = 5;
    v.exmem_regwr = 1; v.memwb_regwr = 1; v.fa = FWD ? 2'b01 : 2'b00; v.fb = v.fa; tbl.push_back(v);
    v = base("fwd_mix");         v.ex_rs = 5; v.ex_rt = 7; v.exmem_wsel = 7; v.exmem_regwr = 1;
    v.memwb_wsel = 5; v.memwb_regwr = 1; v.fa = FWD ? 2'b10 : 2'b00; v.fb = FWD ? 2'b01 : 2'b00; tbl.push_back(v);
    v = base("fwd_r0");          v.exmem_regwr = 1; v.memwb_regwr = 1; tbl.push_back(v);
    v = base("fwd_exmem_nowr");  v.ex_rs = 5; v.exmem_wsel = 5; v.memwb_wsel = 5; v.memwb_regwr = 1;
    v.fa = FWD ? 2'b10 : 2'b00; tbl.push_back(v);
    v = base("raw_exmem");       v.id_rs = 5; v.use_rs = 1; v.exmem_wsel = 5; v.exmem_regwr = 1; v.ex_rs = 5;
    v.ctl = FWD ? C_NORM : C_STALL; v.fa = FWD ? 2'b01 : 2'b00; tbl.push_back(v);
    v = base("raw_idex_alu");    v.id_rt = 3; v.use_rt = 1; v.idex_wsel = 3; v.idex_regwr = 1;
    v.ctl = FWD ? C_NORM : C_STALL; tbl.push_back(v);
    v = base("load_unused_src"); v.idex_memread = 1; v.idex_regwr = 1; v.idex_wsel = 2; v.id_rs = 2; tbl.push_back(v);
    v = base("load_r0");         v.idex_memread = 1; v.idex_regwr = 1; v.use_rs = 1; tbl.push_back(v);
    v = base("hit_no_miss");     v.mem_ren = 1; v.dhit = 1; tbl.push_back(v);
    v = base("flush_over_raw");  v.bfl = 1; v.id_rs = 5; v.use_rs = 1; v.exmem_wsel = 5; v.exmem_regwr = 1;
    v.ctl = C_FLUSH; v.fa = 2'b00; tbl.push_back(v);
    v = base("flush_over_load"); v.jfl = 1; v.idex_memread = 1; v.idex_regwr = 1; v.idex_wsel = 2;
    v.id_rs = 2; v.use_rs = 1; v.ctl = C_FLUSH; tbl.push_back(v);

    // Reset state: RUN with all inputs low.
    RST = 1'b1; idle(); ihit = 1'b0;
    cyc(); settle();
    chk("rst_ctl", 32'(ctl_a), 32'h00);
    chk("rst_fwdA", 32'(a_fwda), 32'h0);
    chk("rst_fwdB", 32'(a_fwdb), 32'h0);
    chk("rst_halted", 32'(a_halted), 32'h0);
    chk("rst_timeout", 32'(a_tmo), 32'h0);
    chk("rst_stall", 32'(a_stall), 32'h0);
    cyc(); RST = 1'b0; ihit = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      settle();
      chk({tbl[i].name, "_ctl"}, 32'(ctl_a), 32'(tbl[i].ctl));
      chk({tbl[i].name, "_fwdA"}, 32'(a_fwda), 32'(tbl[i].fa));
      chk({tbl[i].name, "_fwdB"}, 32'(a_fwdb), 32'(tbl[i].fb));
      cyc();
    end

    // Load-use, two bubbles.
    do_reset(); load_use();
    settle(); chk("lu_c1_ctl", 32'(ctl_a), 32'(C_STALL));
    cyc(); settle(); chk("lu_c2_ctl", 32'(ctl_a), 32'(C_STALL));
    cyc(); idle(); settle();
    chk("lu_c3_ctl", 32'(ctl_a), 32'(C_NORM));
    chk("lu_stall", 32'(a_stall), 32'd2);

    // Miss: four cycles without dhit, then dhit.
    do_reset(); mem_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("miss_wait_ctl", 32'(ctl_a), 32'h00); cyc();
    end
    dhit = 1'b1; settle(); chk("miss_dhit_ctl", 32'(ctl_a), 32'(C_DHIT));
    cyc(); idle(); settle();
    chk("miss_after_ctl", 32'(ctl_a), 32'(C_NORM));
    chk("miss_stall", 32'(a_stall), 32'd5);
    chk("miss_no_timeout", 32'(a_tmo), 32'h0);

    // Timeout after eight MEMWAIT cycles; sticky until reset.
    do_reset(); mem_wen = 1'b1;
    cyc();
    repeat (7) cyc();
    settle(); chk("tmo_at7", 32'(a_tmo), 32'h0);
    cyc(); settle(); chk("tmo_at8", 32'(a_tmo), 32'h1);
    cyc(); dhit = 1'b1; cyc(); idle(); settle();
    chk("tmo_after_dhit", 32'(a_tmo), 32'h1);
    chk("tmo_stall", 32'(a_stall), 32'd11);
    repeat (3) cyc();
    settle(); chk("tmo_sticky", 32'(a_tmo), 32'h1);
    cyc(); do_reset(); settle(); chk("tmo_cleared", 32'(a_tmo), 32'h0);

    // Miss beats a simultaneous branch flush; flush lands after dhit.
    do_reset(); mem_ren = 1'b1; branch_flush = 1'b1;
    settle(); chk("prio_miss_ctl", 32'(ctl_a), 32'h00);
    cyc(); settle(); chk("prio_wait_ctl", 32'(ctl_a), 32'h00);
    cyc(); dhit = 1'b1; settle(); chk("prio_dhit_ctl", 32'(ctl_a), 32'(C_DHIT));
    cyc(); mem_ren = 1'b0; dhit = 1'b0; settle(); chk("prio_flush_ctl", 32'(ctl_a), 32'(C_FLUSH));
    cyc(); idle();

    // Halt during the load-use stall.
    do_reset(); load_use();
    settle(); chk("halt_c1_ctl", 32'(ctl_a), 32'(C_STALL));
    cyc(); mem_halt = 1'b1; settle();
    chk("halt_c2_ctl", 32'(ctl_a), 32'h00);
    chk("halt_c2_halted", 32'(a_halted), 32'h0);
    cyc(); idle(); settle();
    chk("halted_flag", 32'(a_halted), 32'h1);
    chk("halted_ctl", 32'(ctl_a), 32'h00);
    chk("halted_stall", 32'(a_stall), 32'd2);
    repeat (3) cyc();
    settle();
    chk("halted_stall_frozen", 32'(a_stall), 32'd2);
    chk("halted_absorbing", 32'(a_halted), 32'h1);
    cyc(); RST = 1'b1; cyc(); RST = 1'b0; settle();
    chk("unhalt_flag", 32'(a_halted), 32'h0);
    chk("unhalt_ctl", 32'(ctl_a), 32'(C_NORM));
    chk("unhalt_stall", 32'(a_stall), 32'd0);

    // Reset mid-MEMWAIT.
    cyc(); do_reset(); mem_ren = 1'b1;
    cyc(); cyc(); RST = 1'b1; cyc(); RST = 1'b0; idle(); settle();
    chk("rst_memwait_ctl", 32'(ctl_a), 32'(C_NORM));
    chk("rst_memwait_stall", 32'(a_stall), 32'd0);

    // Reset mid-LDSTALL on the LOAD_LAT=4 instance.
    cyc(); do_reset(); load_use();
    cyc(); RST = 1'b1; idle(); cyc(); RST = 1'b0; settle();
    chk("rst_ldstall_b_ctl", 32'(ctl_b), 32'(C_NORM));
    chk("rst_ldstall_b_stall", 32'(b_stall), 32'd0);
    chk("rst_ldstall_a_ctl", 32'(ctl_a), 32'(C_NORM));

    // Stall counter saturation (3-bit instance).
    cyc(); do_reset(); ihit = 1'b0;
    repeat (10) cyc();
    settle();
    chk("sat_b_stall", 32'(b_stall), 32'd7);
    chk("sat_a_stall", 32'(a_stall), 32'd10);
    cyc(); ihit = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
